// File: rtl/scaler_h_ctrl_if.sv
// scaler_h_ctrl_if: scale-step configuration handshake between the register
// interface (master) and scaler_h_ctrl (slave).
`timescale 1ns/1ps
interface scaler_h_ctrl_if #(
  parameter int unsigned STEP_WIDTH = 16
);
  logic [STEP_WIDTH-1:0] cfg_step_i;
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic                  cfg_ack_o;

  modport master (
    output cfg_step_i, cfg_valid_i,
    input  cfg_ready_o, cfg_ack_o
  );

  modport slave (
    input  cfg_step_i, cfg_valid_i,
    output cfg_ready_o, cfg_ack_o
  );
endinterface

// File: rtl/scaler_h_ctrl.sv
// scaler_h_ctrl: control and sequencing for scaler_h.
// Holds scale-step requests in a shadow register and commits them only during
// vertical blanking with the scaler drained. Optional statistics (per-line
// pixel counts, line count, frame pulse, width-change errors) are built when
// SCALER_H_CTRL_STATS_EN is defined; otherwise those outputs read 0.
`timescale 1ns/1ps
module scaler_h_ctrl #(
  parameter int unsigned STEP       = 4096,
  parameter int unsigned STEP_WIDTH = 16,
  parameter int unsigned STEP_MIN   = 1024,
  parameter int unsigned STEP_MAX   = 16383,
  parameter int unsigned CNT_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  scaler_h_ctrl_if.slave        cfg,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic                  hs_s_i,
  input  logic                  de_s_i,
  output logic [STEP_WIDTH-1:0] scale_step_o,
  output logic [CNT_WIDTH-1:0]  in_width_o,
  output logic [CNT_WIDTH-1:0]  out_width_o,
  output logic [CNT_WIDTH-1:0]  lines_o,
  output logic                  frame_done_o,
  output logic [2:0]            err_o
);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t                state;
  logic [STEP_WIDTH-1:0] shadow;
  logic                  commit_ok_q;
  logic                  first_q;
  logic                  err_step;
  logic                  step_legal;

  assign step_legal = (cfg.cfg_step_i >= STEP_WIDTH'(STEP_MIN)) &&
                      (cfg.cfg_step_i <= STEP_WIDTH'(STEP_MAX));

  // Safe-commit condition registered once: vblank, scaler output drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) commit_ok_q <= 1'b0;
    else      commit_ok_q <= vs_i && hs_s_i && !de_s_i && !de_i;
  end

  // Config FSM with registered ready/ack/step outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      shadow          <= '0;
      first_q         <= 1'b0;
      err_step        <= 1'b0;
      scale_step_o    <= STEP_WIDTH'(STEP);
      cfg.cfg_ready_o <= 1'b1;
      cfg.cfg_ack_o   <= 1'b0;
    end else begin
      cfg.cfg_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid_i && cfg.cfg_ready_o) begin
            if (step_legal) begin
              shadow          <= cfg.cfg_step_i;
              first_q         <= 1'b1;
              cfg.cfg_ready_o <= 1'b0;
              state           <= PENDING;
            end else begin
              err_step <= 1'b1;
            end
          end
        end
        PENDING: begin
          // commit_ok_q in the first PENDING cycle reflects the accept
          // cycle itself, so it is skipped; the earliest usable sample is
          // the cycle after accept, giving a 2-cycle minimum latency.
          first_q <= 1'b0;
          if (!first_q && commit_ok_q) begin
            scale_step_o  <= shadow;
            cfg.cfg_ack_o <= 1'b1;
            state         <= APPLY;
          end
        end
        APPLY: begin
          cfg.cfg_ready_o <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCALER_H_CTRL_STATS_EN
  logic                 hs_q, vs_q, hs_s_q;
  logic                 hs_rise, hs_s_rise, vs_rise, vs_fall;
  logic [CNT_WIDTH-1:0] in_cnt, out_cnt, line_cnt, in_ref, out_ref;
  logic                 in_first, out_first, err_in, err_out;

  assign hs_rise   = hs_i && !hs_q;
  assign hs_s_rise = hs_s_i && !hs_s_q;
  assign vs_rise   = vs_i && !vs_q;
  assign vs_fall   = !vs_i && vs_q;

  // Sync history for edge detection; resets to blanking so no edge fires at start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      hs_s_q <= 1'b1;
    end else begin
      hs_q   <= hs_i;
      vs_q   <= vs_i;
      hs_s_q <= hs_s_i;
    end
  end

  // Input pixel counter, line width capture and in-frame width check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt     <= '0;
      in_width_o <= '0;
      in_ref     <= '0;
      in_first   <= 1'b1;
      err_in     <= 1'b0;
    end else begin
      if (hs_rise) begin
        in_width_o <= in_cnt;
        in_cnt     <= '0;
        if (!vs_i) begin
          if (in_first) begin
            in_ref   <= in_cnt;
            in_first <= 1'b0;
          end else if (in_cnt != in_ref) begin
            err_in <= 1'b1;
          end
        end
      end else if (!hs_i && de_i && in_cnt != '1) begin
        in_cnt <= in_cnt + CNT_WIDTH'(1);
      end
      if (vs_rise) in_first <= 1'b1;
    end
  end

  // Output pixel counter; lines with no output data (blanking still
  // draining through the scaler) are not used as width reference or checked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt     <= '0;
      out_width_o <= '0;
      out_ref     <= '0;
      out_first   <= 1'b1;
      err_out     <= 1'b0;
    end else begin
      if (hs_s_rise) begin
        out_width_o <= out_cnt;
        out_cnt     <= '0;
        if (!vs_i && out_cnt != '0) begin
          if (out_first) begin
            out_ref   <= out_cnt;
            out_first <= 1'b0;
          end else if (out_cnt != out_ref) begin
            err_out <= 1'b1;
          end
        end
      end else if (!hs_s_i && de_s_i && out_cnt != '1) begin
        out_cnt <= out_cnt + CNT_WIDTH'(1);
      end
      if (vs_rise) out_first <= 1'b1;
    end
  end

  // Line counter, frame line count capture and frame-done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_cnt     <= '0;
      lines_o      <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= vs_rise;
      if (vs_rise) lines_o <= line_cnt;
      if (vs_fall) line_cnt <= '0;
      else if (hs_rise && !vs_i && line_cnt != '1) line_cnt <= line_cnt + CNT_WIDTH'(1);
    end
  end

  assign err_o = {err_out, err_in, err_step};
`else
  logic unused_hs;
  assign unused_hs    = hs_i;
  assign in_width_o   = '0;
  assign out_width_o  = '0;
  assign lines_o      = '0;
  assign frame_done_o = 1'b0;
  assign err_o        = {2'b00, err_step};
`endif

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// tb_scaler_h_ctrl: randomized scoreboard bench for scaler_h_ctrl.
// The bench plays the role of scaler_h: it generates input frames and an
// output stream whose width is floor(width*4096/step) for the step in force.
`timescale 1ns/1ps
module tb_scaler_h_ctrl;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 13;
  localparam int VB = 16;
  localparam int HB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hs_i = 1'b1, vs_i = 1'b1, de_i = 1'b0, hs_s_i = 1'b1, de_s_i = 1'b0;
  logic [SW-1:0] scale_step_o;
  logic [CW-1:0] in_width_o, out_width_o, lines_o;
  logic          frame_done_o;
  logic [2:0]    err_o;

  scaler_h_ctrl_if #(.STEP_WIDTH(SW)) cfg ();

  scaler_h_ctrl #(
    .STEP(4096), .STEP_WIDTH(SW), .STEP_MIN(1024), .STEP_MAX(16383), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg.slave),
    .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i), .hs_s_i(hs_s_i), .de_s_i(de_s_i),
    .scale_step_o(scale_step_o), .in_width_o(in_width_o), .out_width_o(out_width_o),
    .lines_o(lines_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int step; int cyc; } ack_t;
  typedef struct { int lines; int inw; int outw; } frm_t;
  ack_t ack_q[$];
  frm_t frm_q[$];

  int       checks = 0;
  int       errors = 0;
  int       model_step = 4096;
  bit [2:0] err_exp = 3'b000;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input int s);
    return s >= 1024 && s <= 16383;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents an event
  always @(negedge clk) begin
    ack_t a;
    frm_t f;
    if (cfg.cfg_ack_o === 1'b1) begin
      check("ack_expected", int'(ack_q.size() > 0), 1);
      if (ack_q.size() > 0) begin
        a = ack_q.pop_front();
        check("ack_step", scale_step_o, a.step);
        check("ack_ready_low", cfg.cfg_ready_o, 0);
        if (a.cyc >= 0) check("ack_latency", cyc, a.cyc);
        else            check("ack_in_vblank", vs_i, 1);
      end
    end
    if (frame_done_o === 1'b1) begin
      check("frame_expected", int'(frm_q.size() > 0), 1);
      if (frm_q.size() > 0) begin
        f = frm_q.pop_front();
        check("frame_lines", lines_o, f.lines);
        check("frame_in_width", in_width_o, f.inw);
        check("frame_out_width", out_width_o, f.outw);
      end
    end
  end

  // Handshake one request; acc is the index of the accepting clock edge
  task automatic send_cfg(input int s, output int acc, output int n);
    logic r;
    cfg.cfg_step_i  = SW'(s);
    cfg.cfg_valid_i = 1'b1;
    n = 0;
    r = 1'b0;
    acc = -1;
    while (!r && n < 500) begin
      @(negedge clk);
      r   = cfg.cfg_ready_o;
      acc = cyc + 1;
      @(posedge clk);
      n++;
    end
    #1 cfg.cfg_valid_i = 1'b0;
    check("cfg_handshake_timeout", r, 1);
  endtask

  // Issue a request and record what the DUT must do with it
  task automatic request(input int s, input bit blank, output int n);
    int acc;
    send_cfg(s, acc, n);
    if (legal(s)) ack_q.push_back('{s, blank ? acc + 2 : -1});
    else          err_exp[0] = 1'b1;
  endtask

  // One frame at the step in force; line index sh is one input pixel short
  task automatic run_frame(input int w, input int h, input int sh);
    int wl, nl, st;
    st = model_step;
    wl = w;
    nl = 0;
    vs_i = 1'b0;
    tick();
    for (int l = 0; l < h; l++) begin
      wl = (l == sh) ? w - 1 : w;
      nl = (wl * 4096) / st;
      hs_i = 1'b0; hs_s_i = 1'b0;
      for (int c = 0; c < ((wl > nl) ? wl : nl); c++) begin
        de_i = (c < wl); de_s_i = (c < nl);
        tick();
      end
      hs_i = 1'b1; hs_s_i = 1'b1; de_i = 1'b0; de_s_i = 1'b0;
      idle(HB);
    end
`ifdef SCALER_H_CTRL_STATS_EN
    frm_q.push_back('{h, wl, nl});
    if (sh > 0 && sh < h) begin
      err_exp[1] = 1'b1;
      if (((w - 1) * 4096) / st != (w * 4096) / st) err_exp[2] = 1'b1;
    end
`endif
    vs_i = 1'b1;
    idle(VB);
  endtask

  initial begin
    int acc, n, w, h, s;
    bit blank;
    cfg.cfg_valid_i = 1'b0;
    cfg.cfg_step_i  = '0;

    idle(3);
    check("rst_step", scale_step_o, 4096);
    check("rst_ready", cfg.cfg_ready_o, 1);
    check("rst_ack", cfg.cfg_ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_lines", lines_o, 0);
    rst = 1'b1;
    idle(3);
    check("idle_step", scale_step_o, 4096);
    check("idle_ready", cfg.cfg_ready_o, 1);

    request(6144, 1'b1, n);
    idle(6);
    model_step = 6144;
    check("blank_commit_step", scale_step_o, 6144);
    request(4096, 1'b1, n);
    idle(6);
    model_step = 4096;

    fork
      run_frame(600, 12, -1);
      begin
        idle(1000);
        request(6144, 1'b0, n);
        idle(3);
        check("midframe_hold_step", scale_step_o, 4096);
        check("midframe_pending_ready", cfg.cfg_ready_o, 0);
      end
    join
    model_step = 6144;
    run_frame(600, 12, -1);
    check("frame_err", err_o, int'(err_exp));

    request(512, 1'b1, n);
    check("illegal_one_cycle", n, 1);
    idle(6);
    check("illegal_step_kept", scale_step_o, 6144);
    check("illegal_err", err_o, int'(err_exp));
    check("illegal_ready", cfg.cfg_ready_o, 1);

    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(20, 80);
      h = $urandom_range(11, 14);
      if ($urandom_range(0, 3) == 0)
        s = $urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(16384, 65535);
      else
        s = $urandom_range(1024, 16383);
      blank = 1'($urandom_range(0, 1));
      if (blank) begin
        request(s, 1'b1, n);
        idle(6);
        if (legal(s)) model_step = s;
        run_frame(w, h, -1);
      end else begin
        fork
          run_frame(w, h, -1);
          begin
            idle($urandom_range(5, (w * h) / 2));
            request(s, 1'b0, n);
          end
        join
        if (legal(s)) model_step = s;
      end
      check("rand_err", err_o, int'(err_exp));
      check("rand_step", scale_step_o, model_step);
    end

    request(4096, 1'b1, n);
    idle(6);
    model_step = 4096;
    run_frame(40, 12, 9);
    check("short_line_err", err_o, int'(err_exp));
`ifndef SCALER_H_CTRL_STATS_EN
    check("nostats_in_width", in_width_o, 0);
    check("nostats_out_width", out_width_o, 0);
    check("nostats_lines", lines_o, 0);
`endif

    vs_i = 1'b0;
    tick();
    send_cfg(8192, acc, n);
    idle(4);
    check("pend_hold_ready", cfg.cfg_ready_o, 0);
    check("pend_hold_step", scale_step_o, 4096);
    rst = 1'b0;
    tick();
    check("pend_rst_ready", cfg.cfg_ready_o, 1);
    check("pend_rst_step", scale_step_o, 4096);
    idle(2);
    rst = 1'b1;
    model_step = 4096;
    err_exp = 3'b000;
    idle(2);
    check("pend_release_ready", cfg.cfg_ready_o, 1);
    check("pend_release_err", err_o, 0);
`ifdef SCALER_H_CTRL_STATS_EN
    frm_q.push_back('{0, 0, 0});
`endif
    vs_i = 1'b1;
    idle(VB);
    check("pend_no_commit_step", scale_step_o, 4096);

    check("ack_queue_drained", ack_q.size(), 0);
    check("frame_queue_drained", frm_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/scaler_h_ctrl.md
Name: scaler_h_ctrl

Overview:
- Control and sequencing block for the horizontal scaler, `scaler_h`.
- Accepts scale-step configuration requests through a valid/ready handshake and holds each request in a shadow register.
- Commits a held request to the scaler's `scale_step` input only at a safe frame boundary: vertical blanking with the scaler output drained.
- Monitors the scaler input and output sync streams and reports per-line pixel counts, line count and error flags. The block sits beside `scaler_h`, between the register interface and the video pipe.

Parameters:
- STEP, 4096, fixed-point value for 1.000 scale in (4.12) unsigned format.
- STEP_WIDTH, 16, width of the scale-step word.
- STEP_MIN, 1024, smallest legal step (0.25).
- STEP_MAX, 16383, largest legal step (just under 4.0).
- CNT_WIDTH, 13, width of the pixel and line counters. Counters saturate at all-ones.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cfg_step_i  in  STEP_WIDTH  requested scale step, (4.12) format
- cfg_valid_i  in  1  configuration request valid
- cfg_ready_o  out  1  block can accept a request
- cfg_ack_o  out  1  one-cycle pulse when the requested step is committed
- hs_i  in  1  scaler input hsync (1 = horizontal blanking)
- vs_i  in  1  scaler input vsync (1 = vertical blanking)
- de_i  in  1  scaler input data enable
- hs_s_i  in  1  scaler output hsync
- de_s_i  in  1  scaler output data enable
- scale_step_o  out  STEP_WIDTH  drives `scaler_h.scale_step`
- in_width_o  out  CNT_WIDTH  input pixel count of the last completed line
- out_width_o  out  CNT_WIDTH  output pixel count of the last completed line
- lines_o  out  CNT_WIDTH  input line count of the last completed frame
- frame_done_o  out  1  one-cycle pulse on the vs_i rising edge
- err_o  out  3  sticky error bits: [0] illegal step rejected, [1] input width changed within a frame, [2] output width changed within a frame

Behaviour:
- Reset values: scale_step_o=STEP, cfg_ready_o=1, cfg_ack_o=0, frame_done_o=0, err_o=0, all counts 0, FSM in IDLE.
- Reset is asynchronous. Asserting it mid-frame or while a request is PENDING discards the shadow register with no ack.
- FSM states: IDLE, PENDING, APPLY.
- IDLE:
  - cfg_ready_o=1.
  - On cfg_valid_i && cfg_ready_o with STEP_MIN<=cfg_step_i<=STEP_MAX: capture the shadow register and go to PENDING.
  - An out-of-range step is consumed (the handshake completes), err_o[0] is set, and the FSM stays in IDLE. scale_step_o is unchanged.
- PENDING:
  - cfg_ready_o=0.
  - Commit condition, sampled registered: vs_i==1 && hs_s_i==1 && de_s_i==0 && de_i==0.
  - The condition must be seen true in the cycle after the request is accepted, never in the accept cycle itself. A request accepted during blanking therefore commits 2 cycles after the accept.
  - While the condition is false the request is held indefinitely.
- APPLY: one cycle. scale_step_o is loaded from the shadow register, cfg_ack_o=1, next state IDLE. cfg_ready_o=0 in this cycle.
- Latency from accept to ack is at least 2 cycles. Exactly one commit happens per request.
- Input edges: hs_i and vs_i are registered once and edges are detected against the registered copy. No extra synchronisers (same clock domain).
- Input counter:
  - Counts de_i while hs_i==0.
  - On the hs_i rising edge, in_width_o is loaded with the count and the counter is cleared.
- Output counter: same rule using de_s_i and hs_s_i, loading out_width_o.
- Line counter:
  - Increments on each hs_i rising edge while vs_i==0.
  - Clears on the vs_i falling edge.
  - On the vs_i rising edge, lines_o is loaded and frame_done_o pulses.
- Width checks:
  - The first line of a frame sets the reference width.
  - Any later line in the same frame with a different input width sets err_o[1].
  - Any later line with a different output width sets err_o[2].
- All counters saturate at 2^CNT_WIDTH-1.
- err_o bits clear only on reset.
- Simultaneous vs_i rising and cfg accept: the request goes to PENDING and commits on a later cycle when the condition holds (it may still be in the same blanking interval).

Optional Feature:
- Macro: SCALER_H_CTRL_STATS_EN.
- Defined: the width and line counters, frame_done_o and err_o[2:1] are implemented as above.
- Undefined: counters are removed; in_width_o, out_width_o, lines_o, frame_done_o and err_o[2:1] are tied to 0. Only the config FSM and err_o[0] remain.

Test Plan:
- Reset released, no config: scale_step_o=4096, cfg_ready_o=1, err_o=0.
- Request cfg_step_i=6144 during vertical blanking (vs_i=1, scaler idle): cfg_ack_o pulses 2 cycles after accept, then scale_step_o=6144.
- Request 6144 mid-frame on a 600x600 image: scale_step_o stays 4096 until after the last line. It commits during blanking, and the next frame gives in_width_o=600, out_width_o=400, lines_o=600, with frame_done_o pulsing once per frame.
- Request cfg_step_i=512: accepted in 1 cycle, err_o[0]=1, no ack, scale_step_o unchanged.
- Assert rst while PENDING: no ack; after release scale_step_o=4096 and cfg_ready_o=1.
- With STATS_EN defined, shorten line 10 of a frame to 599 pixels: err_o[1]=1 and err_o[2]=1. Without the macro, all stat outputs read 0.
